// File: rtl/sevenseg_scan_if.sv
// Display-side bundle for sevenseg_scan: scan strobe, value/dp source and the pin drives.
// master = value/strobe source and pin consumer, slave = the scanner.
interface sevenseg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  clk_en_pi;
  logic                  enable_pi;
  logic [4*DIGITS-1:0]   value_pi;
  logic [DIGITS-1:0]     dp_pi;
  logic [6:0]            seg_po;
  logic                  dp_po;
  logic [DIGITS-1:0]     an_po;
  logic                  frame_po;

  modport master (
    output clk_en_pi, enable_pi, value_pi, dp_pi,
    input  seg_po, dp_po, an_po, frame_po
  );

  modport slave (
    input  clk_en_pi, enable_pi, value_pi, dp_pi,
    output seg_po, dp_po, an_po, frame_po
  );
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with inter-digit blanking gap.
// Optional leading-zero blanking when SEVENSEG_LZB_EN is defined.
module sevenseg_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned ON_TICKS    = 14,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic            clk_pi,
  input  logic            rst_n_pi,
  sevenseg_scan_if.slave  bus
);

  localparam int unsigned VW      = 4 * DIGITS;
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_OFF, S_ON, S_BLANK} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     val_q, val_d;
  logic [DIGITS-1:0] dpl_q, dpl_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic              latch;
  logic              advance;
  logic [3:0]        nib;
  logic              dp_sel;
  logic              blank_digit;
  logic              upper_zero;

  // Active-low gfedcba pattern for one hex nibble
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      dpl_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      dpl_q   <= dpl_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  // Next state; outputs are decoded from the next state so they switch on the same edge
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    dpl_d       = dpl_q;
    frame_d     = 1'b0;
    latch       = 1'b0;
    advance     = 1'b0;
    nib         = 4'h0;
    dp_sel      = 1'b0;
    blank_digit = 1'b0;
    upper_zero  = 1'b1;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    an_d        = '1;

    if (bus.clk_en_pi) begin
      if (!bus.enable_pi) begin
        state_d = S_OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_OFF: begin
            latch   = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_ON;
          end
          S_ON: begin
            if (cnt_q == CW'(ON_TICKS - 1)) begin
              cnt_d = '0;
              if (BLANK_TICKS == 0) advance = 1'b1;
              else                  state_d = S_BLANK;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_BLANK: begin
            if (cnt_q == CW'(BLANK_TICKS - 1)) begin
              cnt_d   = '0;
              advance = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: state_d = S_OFF;
        endcase
      end
    end

    if (advance) begin
      state_d = S_ON;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = '0;
        latch = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Frame boundary: capture a fresh value so a frame never mixes old and new digits
    if (latch) begin
      val_d   = bus.value_pi;
      dpl_d   = bus.dp_pi;
      frame_d = 1'b1;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib    = val_d[4*i +: 4];
        dp_sel = dpl_d[i];
      end
    end

`ifdef SEVENSEG_LZB_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (val_d[4*i +: 4] == 4'h0);
      if ((idx_d == IW'(i)) && upper_zero) blank_digit = 1'b1;
    end
`endif

    if (state_d == S_ON) begin
      for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_d != IW'(i));
      seg_d = blank_digit ? 7'h7F : decode(nib);
      dp_d  = blank_digit ? 1'b1  : ~dp_sel;
    end
  end

  assign bus.seg_po   = seg_q;
  assign bus.dp_po    = dp_q;
  assign bus.an_po    = an_q;
  assign bus.frame_po = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: stimulus pushes per-cycle expected pin states,
// a negedge monitor pops and compares them.
module tb_sevenseg_scan;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SLOT   = 16;   // ON 14 + BLANK 2
  localparam int unsigned FRAME  = 64;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    int         ph;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   phase;
  exp_t q[$];

  sevenseg_scan_if #(.DIGITS(DIGITS)) bus ();

  sevenseg_scan #(.DIGITS(DIGITS), .ON_TICKS(14), .BLANK_TICKS(2)) dut (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t dark(input int ph);
    exp_t e;
    e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0; e.ph = ph;
    return e;
  endfunction

  // Expected pins c ticks into a frame showing v with decimal points dpv
  function automatic exp_t scan_exp(input int c, input logic [15:0] v,
                                    input logic [3:0] dpv, input int ph);
    exp_t e;
    int d;
    int r;
    logic [15:0] above;
    d = c / SLOT;
    r = c % SLOT;
    e = dark(ph);
    e.frame = (c == 0);
    if (r < 14) begin
      e.an    = ~(4'b0001 << d);
      e.seg   = seg_of(v[4*d +: 4]);
      e.dp    = ~dpv[d];
      above   = v >> (4 * d);
`ifdef SEVENSEG_LZB_EN
      if (d > 0 && above == 16'h0000) begin
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
`else
      if (above == 16'hFFFF) e.ph = ph;
`endif
    end
    return e;
  endfunction

  task automatic step_push(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  // Monitor: one comparison per cycle that has an expectation queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.an_po !== e.an || bus.seg_po !== e.seg ||
            bus.dp_po !== e.dp || bus.frame_po !== e.frame) begin
          errors++;
          if (errors <= 20)
            $display("FAIL ph%0d t=%0t an=%b/%b seg=%h/%h dp=%b/%b frame=%b/%b (got/want)",
                     e.ph, $time, bus.an_po, e.an, bus.seg_po, e.seg,
                     bus.dp_po, e.dp, bus.frame_po, e.frame);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout q=%0d", q.size());
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.clk_en_pi = 1'b0;
    bus.enable_pi = 1'b0;
    bus.value_pi  = 16'h0000;
    bus.dp_pi     = 4'b0000;

    // Reset with strobe low
    phase = 1;
    for (int k = 0; k < 3; k++) step_push(dark(phase));
    rst_n = 1'b1;

    // Continuous scan of 12AF, then 0000 loaded mid-frame at digit 1
    phase = 2;
    bus.value_pi  = 16'h12AF;
    bus.dp_pi     = 4'b0100;
    bus.enable_pi = 1'b1;
    bus.clk_en_pi = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step_push(scan_exp(c, (f < 2) ? 16'h12AF : 16'h0000, 4'b0100, phase + f));
        if (f == 1 && c == 20) bus.value_pi = 16'h0000;
      end
    end

    // Strobe every 4th cycle
    phase = 6;
    bus.enable_pi = 1'b0;
    step_push(dark(phase));
    bus.enable_pi = 1'b1;
    bus.value_pi  = 16'h8E6B;
    bus.dp_pi     = 4'b1001;
    for (int e4 = 0; e4 < 4 * FRAME + 8; e4++) begin
      exp_t x;
      bus.clk_en_pi = (e4 % 4 == 0);
      x = scan_exp((e4 / 4) % FRAME, 16'h8E6B, 4'b1001, phase);
      x.frame = x.frame && (e4 % 4 == 0);
      step_push(x);
    end

    // Drop enable during digit 2, then restart
    phase = 7;
    bus.clk_en_pi = 1'b1;
    bus.enable_pi = 1'b0;
    step_push(dark(phase));
    bus.enable_pi = 1'b1;
    bus.value_pi  = 16'h4D90;
    bus.dp_pi     = 4'b0000;
    for (int c = 0; c < 37; c++) step_push(scan_exp(c, 16'h4D90, 4'b0000, phase));
    bus.enable_pi = 1'b0;
    for (int k = 0; k < 3; k++) step_push(dark(phase));
    bus.enable_pi = 1'b1;
    phase = 8;
    for (int c = 0; c < 20; c++) step_push(scan_exp(c, 16'h4D90, 4'b0000, phase));

    // Async reset between edges must take effect before the next edge
    phase = 9;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.push_back(dark(phase));
    for (int k = 0; k < 2; k++) step_push(dark(phase));
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) step_push(scan_exp(c, 16'h4D90, 4'b0000, phase));

    // Leading zeros: 0005 then 0000
    phase = 10;
    bus.enable_pi = 1'b0;
    step_push(dark(phase));
    bus.enable_pi = 1'b1;
    bus.value_pi  = 16'h0005;
    bus.dp_pi     = 4'b0010;
    for (int c = 0; c < FRAME; c++) step_push(scan_exp(c, 16'h0005, 4'b0010, phase));
    phase = 11;
    bus.enable_pi = 1'b0;
    step_push(dark(phase));
    bus.enable_pi = 1'b1;
    bus.value_pi  = 16'h0000;
    for (int c = 0; c < 36; c++) step_push(scan_exp(c, 16'h0000, 4'b0010, phase));

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain q=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
